regfile_access_arbiter: RTL

- Shares the 16 x 18-bit register file between two requesters, e.g. the execute unit and a loader/debug port.
- Each requester issues one transaction at a time: an optional write plus two reads.
- The block grants requests round-robin and sequences the register file's enable/load controls.
- It returns the two read words to the granted requester with a valid/ready response handshake.

---
 rtl/regfile_access_arbiter.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/regfile_access_arbiter.sv
// rtl/regfile_access_arbiter.sv - round-robin arbiter sequencing a shared 16 x 18-bit register file
//
// Purpose:
//   Two requesters share one register file. Each transaction carries an optional
//   write plus two reads. A request is accepted in IDLE. The register file is
//   strobed for one ISSUE cycle. The two read words are then held in RESP until
//   the granted requester takes them. Arbitration alternates when both
//   requesters are valid.
//
// Ports:
//   clock, reset              - single clock; synchronous active-high reset
//   reqN_valid / reqN_ready   - request handshake; ready is the accept strobe
//   reqN_write, reqN_waddr, reqN_wdata, reqN_raddr1, reqN_raddr2 - request fields
//   rspN_valid / rspN_ready   - response handshake for requester N
//   rsp_data1, rsp_data2      - read words, meaningful while any rspN_valid
//   rf_enable, rf_load        - register file enable / write strobe (ISSUE only)
//   rf_reg_to_write, rf_data_to_write, rf_reg_to_read1, rf_reg_to_read2
//                             - latched transaction fields toward the register file
//   rf_data_to_read1/2        - registered read data from the register file

module regfile_access_arbiter #(
  parameter int DATA_WIDTH = 18,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,

  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_write,
  input  logic [ADDR_WIDTH-1:0] req0_waddr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  input  logic [ADDR_WIDTH-1:0] req0_raddr1,
  input  logic [ADDR_WIDTH-1:0] req0_raddr2,
  output logic                  rsp0_valid,
  input  logic                  rsp0_ready,

  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_write,
  input  logic [ADDR_WIDTH-1:0] req1_waddr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  input  logic [ADDR_WIDTH-1:0] req1_raddr1,
  input  logic [ADDR_WIDTH-1:0] req1_raddr2,
  output logic                  rsp1_valid,
  input  logic                  rsp1_ready,

  output logic [DATA_WIDTH-1:0] rsp_data1,
  output logic [DATA_WIDTH-1:0] rsp_data2,

  output logic                  rf_enable,
  output logic                  rf_load,
  output logic [ADDR_WIDTH-1:0] rf_reg_to_write,
  output logic [DATA_WIDTH-1:0] rf_data_to_write,
  output logic [ADDR_WIDTH-1:0] rf_reg_to_read1,
  output logic [ADDR_WIDTH-1:0] rf_reg_to_read2,
  input  logic [DATA_WIDTH-1:0] rf_data_to_read1,
  input  logic [DATA_WIDTH-1:0] rf_data_to_read2
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next_state;

  logic                  r_prio;
  logic                  r_gnt;
  logic                  r_write;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [ADDR_WIDTH-1:0] r_raddr1;
  logic [ADDR_WIDTH-1:0] r_raddr2;

  logic                  w_any_valid;
  logic                  w_gnt_id;
  logic                  w_accept;
  logic                  w_rsp_ready_g;

  assign w_any_valid = req0_valid | req1_valid;

  // With a single valid requester it wins outright. With both valid, the
  // round-robin pointer decides.
  assign w_gnt_id = (req0_valid & req1_valid) ? r_prio : req1_valid;

  assign w_rsp_ready_g = r_gnt ? rsp1_ready : rsp0_ready;

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    rsp0_valid   = 1'b0;
    rsp1_valid   = 1'b0;
    rf_enable    = 1'b0;
    rf_load      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_any_valid) begin
          w_accept     = 1'b1;
          w_next_state = ST_ISSUE;
          if (w_gnt_id) begin
            req1_ready = 1'b1;
          end else begin
            req0_ready = 1'b1;
          end
        end
      end

      ST_ISSUE: begin
        rf_enable    = 1'b1;
        rf_load      = r_write;
        w_next_state = ST_RESP;
      end

      ST_RESP: begin
        if (r_gnt) begin
          rsp1_valid = 1'b1;
        end else begin
          rsp0_valid = 1'b1;
        end
        if (w_rsp_ready_g) begin
          w_next_state = ST_IDLE;
        end
      end

      default: begin
        w_next_state = ST_IDLE;
      end
    endcase

    // Reset kills every strobe in the same cycle. Because of this, a write
    // caught in ISSUE never reaches the register file.
    if (reset) begin
      w_accept     = 1'b0;
      w_next_state = ST_IDLE;
      req0_ready   = 1'b0;
      req1_ready   = 1'b0;
      rsp0_valid   = 1'b0;
      rsp1_valid   = 1'b0;
      rf_enable    = 1'b0;
      rf_load      = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_prio   <= 1'b0;
      r_gnt    <= 1'b0;
      r_write  <= 1'b0;
      r_waddr  <= '0;
      r_wdata  <= '0;
      r_raddr1 <= '0;
      r_raddr2 <= '0;
    end else begin
      r_state <= w_next_state;

      if (w_accept) begin
        r_gnt <= w_gnt_id;
        if (w_gnt_id) begin
          r_write  <= req1_write;
          r_waddr  <= req1_waddr;
          r_wdata  <= req1_wdata;
          r_raddr1 <= req1_raddr1;
          r_raddr2 <= req1_raddr2;
        end else begin
          r_write  <= req0_write;
          r_waddr  <= req0_waddr;
          r_wdata  <= req0_wdata;
          r_raddr1 <= req0_raddr1;
          r_raddr2 <= req0_raddr2;
        end
      end

      // The pointer only moves once a response is consumed. The requester
      // just served therefore loses the next tie.
      if ((r_state == ST_RESP) && w_rsp_ready_g) begin
        r_prio <= ~r_gnt;
      end
    end
  end

  assign rf_reg_to_write  = r_waddr;
  assign rf_data_to_write = r_wdata;
  assign rf_reg_to_read1  = r_raddr1;
  assign rf_reg_to_read2  = r_raddr2;

  // The register file output is registered and only changes while rf_enable
  // is high. It therefore stays stable for the whole RESP phase.
  assign rsp_data1 = rf_data_to_read1;
  assign rsp_data2 = rf_data_to_read2;

endmodule
